// File: rtl/instruction_decode_stage_if.sv
// Handshake and decoded-bundle bundle for the instruction decode stage.
// The upstream side presents instruction_word_i/pc_i with in_valid_i and
// sees in_ready_o; the downstream side sees the registered decode bundle
// with out_valid_o and answers with out_ready_i.
interface instruction_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instruction_word_i;
  logic [XLEN-1:0] pc_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [6:0]      opcode_o;
  logic [4:0]      rd_o;
  logic [2:0]      funct3_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [6:0]      funct7_o;
  logic [XLEN-1:0] imm_o;
  logic [XLEN-1:0] pc_o;
  logic            illegal_o;

  // Decode stage side.
  modport slave (
    input  in_valid_i, instruction_word_i, pc_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, opcode_o, rd_o, funct3_o, rs1_o,
           rs2_o, funct7_o, imm_o, pc_o, illegal_o
  );

  // Fetch / consumer side (driver of the stage inputs).
  modport master (
    output in_valid_i, instruction_word_i, pc_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, opcode_o, rd_o, funct3_o, rs1_o,
           rs2_o, funct7_o, imm_o, pc_o, illegal_o
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// RV32I instruction decode stage: one pipeline register holding the decoded
// fields, sign-extended immediate and PC, with a valid/ready handshake on
// both sides and a flush that drops the held and incoming instruction.
// Optional feature macro DECODE_ILLEGAL_TRAP_EN: when defined, illegal
// words raise illegal_o and are replaced by a NOP bundle (pc kept); when
// undefined, illegal_o stays 0 and words pass through with raw slicing.
module instruction_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  instruction_decode_stage_if.slave bus
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t state_reg, state_next;

  logic [31:0] word;
  logic        accept;

  logic [6:0]  opcode_next;
  logic [4:0]  rd_next;
  logic [2:0]  funct3_next;
  logic [4:0]  rs1_next;
  logic [4:0]  rs2_next;
  logic [6:0]  funct7_next;
  logic [31:0] imm32_next;
  logic        decode_illegal;
  logic        illegal_next;
  logic [XLEN-1:0] imm_ext;

  logic [6:0]      opcode_reg;
  logic [4:0]      rd_reg;
  logic [2:0]      funct3_reg;
  logic [4:0]      rs1_reg;
  logic [4:0]      rs2_reg;
  logic [6:0]      funct7_reg;
  logic [XLEN-1:0] imm_reg;
  logic [XLEN-1:0] pc_reg;
  logic            illegal_reg;

  assign word = bus.instruction_word_i;

  // Ready looks only at the output side so upstream never sees a loop
  // through in_valid_i; a flush still suppresses the capture below.
  assign bus.in_ready_o  = (state_reg == S_EMPTY) || bus.out_ready_i;
  assign bus.out_valid_o = (state_reg == S_FULL);
  assign accept          = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;

  // Valid-flag state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next valid state: flush beats load, load beats drain.
  always_comb begin
    state_next = state_reg;
    if (bus.flush_i) begin
      state_next = S_EMPTY;
    end else if (accept) begin
      state_next = S_FULL;
    end else if (bus.out_ready_i) begin
      state_next = S_EMPTY;
    end
  end

  // Field slicing, operand masking, immediate formation and legality check.
  always_comb begin
    opcode_next    = word[6:0];
    rd_next        = word[11:7];
    funct3_next    = word[14:12];
    rs1_next       = word[19:15];
    rs2_next       = word[24:20];
    funct7_next    = word[31:25];
    imm32_next     = '0;
    decode_illegal = 1'b0;

    case (word[6:0])
      OPC_LUI, OPC_AUIPC: begin
        rs1_next   = '0;
        imm32_next = {word[31:12], 12'b0};
      end
      OPC_JAL: begin
        rs1_next   = '0;
        imm32_next = {{11{word[31]}}, word[31], word[19:12], word[20],
                      word[30:21], 1'b0};
      end
      OPC_JALR: begin
        imm32_next     = {{20{word[31]}}, word[31:20]};
        decode_illegal = (word[14:12] != 3'b000);
      end
      OPC_BRANCH: begin
        rd_next    = '0;
        imm32_next = {{19{word[31]}}, word[31], word[7], word[30:25],
                      word[11:8], 1'b0};
      end
      OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
        imm32_next = {{20{word[31]}}, word[31:20]};
      end
      OPC_STORE: begin
        rd_next    = '0;
        imm32_next = {{20{word[31]}}, word[31:25], word[11:7]};
      end
      OPC_OP, OPC_MISC_MEM: begin
        imm32_next = '0;
      end
      default: begin
        decode_illegal = 1'b1;
      end
    endcase

    // Only register-register, store and branch formats read rs2.
    if (!((word[6:0] == OPC_OP) || (word[6:0] == OPC_STORE) ||
          (word[6:0] == OPC_BRANCH))) begin
      rs2_next = '0;
    end

    // Compressed/non-32-bit encodings are never legal here.
    if (word[1:0] != 2'b11) begin
      decode_illegal = 1'b1;
    end

    // With trapping enabled an illegal word becomes addi x0,x0,0.
    illegal_next = TRAP_EN && decode_illegal;
    if (illegal_next) begin
      opcode_next = OPC_OP_IMM;
      rd_next     = '0;
      funct3_next = '0;
      rs1_next    = '0;
      rs2_next    = '0;
      funct7_next = '0;
      imm32_next  = '0;
    end
  end

  // Sign-extend the 32-bit immediate to XLEN by replicating bit 31.
  assign imm_ext[31:0] = imm32_next;
  generate
    for (genvar gi = 32; gi < XLEN; gi++) begin : g_sext
      assign imm_ext[gi] = imm32_next[31];
    end
  endgenerate

  // Bundle register: loads only on an accepted transfer, holds otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opcode_reg  <= '0;
      rd_reg      <= '0;
      funct3_reg  <= '0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      funct7_reg  <= '0;
      imm_reg     <= '0;
      pc_reg      <= '0;
      illegal_reg <= 1'b0;
    end else if (accept) begin
      opcode_reg  <= opcode_next;
      rd_reg      <= rd_next;
      funct3_reg  <= funct3_next;
      rs1_reg     <= rs1_next;
      rs2_reg     <= rs2_next;
      funct7_reg  <= funct7_next;
      imm_reg     <= imm_ext;
      pc_reg      <= bus.pc_i;
      illegal_reg <= illegal_next;
    end
  end

  assign bus.opcode_o  = opcode_reg;
  assign bus.rd_o      = rd_reg;
  assign bus.funct3_o  = funct3_reg;
  assign bus.rs1_o     = rs1_reg;
  assign bus.rs2_o     = rs2_reg;
  assign bus.funct7_o  = funct7_reg;
  assign bus.imm_o     = imm_reg;
  assign bus.pc_o      = pc_reg;
  assign bus.illegal_o = illegal_reg;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage: a vector table of decoded
// expectations streamed back-to-back, then stall, flush and reset sequences.
module tb_instruction_decode_stage;

  localparam int XLEN = 32;
  localparam int NVEC = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  instruction_decode_stage_if #(.XLEN(XLEN)) bus ();

  instruction_decode_stage #(.XLEN(XLEN)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_bundle(input string tag, input vec_t v);
    chk({tag, ".valid"},   64'(bus.out_valid_o), 64'(1'b1));
    chk({tag, ".opcode"},  64'(bus.opcode_o),    64'(v.opc));
    chk({tag, ".rd"},      64'(bus.rd_o),        64'(v.rd));
    chk({tag, ".funct3"},  64'(bus.funct3_o),    64'(v.f3));
    chk({tag, ".rs1"},     64'(bus.rs1_o),       64'(v.rs1));
    chk({tag, ".rs2"},     64'(bus.rs2_o),       64'(v.rs2));
    chk({tag, ".funct7"},  64'(bus.funct7_o),    64'(v.f7));
    chk({tag, ".imm"},     64'(bus.imm_o),       64'(v.imm));
    chk({tag, ".pc"},      64'(bus.pc_o),        64'(v.pc));
    chk({tag, ".illegal"}, 64'(bus.illegal_o),   64'(v.ill));
  endtask

  initial begin
    // instr, pc, opcode, rd, funct3, rs1, rs2, funct7, imm, illegal
    vecs[0]  = '{32'h00500093, 32'h100, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000005, 1'b0}; // addi x1,x0,5
    vecs[1]  = '{32'h123450B7, 32'h104, 7'h37, 5'd1, 3'd5, 5'd0, 5'd0, 7'h09, 32'h12345000, 1'b0}; // lui x1
    vecs[2]  = '{32'h00112223, 32'h108, 7'h23, 5'd0, 3'd2, 5'd2, 5'd1, 7'h00, 32'h00000004, 1'b0}; // sw x1,4(x2)
    vecs[3]  = '{32'hFE000EE3, 32'h10C, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h7F, 32'hFFFFFFFC, 1'b0}; // beq -4
    vecs[4]  = '{32'hFFDFF0EF, 32'h110, 7'h6F, 5'd1, 3'd7, 5'd0, 5'd0, 7'h7F, 32'hFFFFFFFC, 1'b0}; // jal x1,-4
    vecs[5]  = '{32'h002081B3, 32'h114, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'h00000000, 1'b0}; // add x3,x1,x2
    vecs[6]  = '{32'hFFF32283, 32'h118, 7'h03, 5'd5, 3'd2, 5'd6, 5'd0, 7'h7F, 32'hFFFFFFFF, 1'b0}; // lw x5,-1(x6)
    vecs[7]  = '{32'h80000117, 32'h11C, 7'h17, 5'd2, 3'd0, 5'd0, 5'd0, 7'h40, 32'h80000000, 1'b0}; // auipc x2
    vecs[8]  = '{32'h000280E7, 32'h120, 7'h67, 5'd1, 3'd0, 5'd5, 5'd0, 7'h00, 32'h00000000, 1'b0}; // jalr x1,0(x5)
    vecs[9]  = '{32'h34011073, 32'h124, 7'h73, 5'd0, 3'd1, 5'd2, 5'd0, 7'h1A, 32'h00000340, 1'b0}; // csrrw
    vecs[10] = '{32'h0FF0000F, 32'h128, 7'h0F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h07, 32'h00000000, 1'b0}; // fence
`ifdef DECODE_ILLEGAL_TRAP_EN
    vecs[11] = '{32'h000290E7, 32'h12C, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b1}; // jalr f3!=0
    vecs[12] = '{32'hFFFFFFFF, 32'h130, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b1};
    vecs[13] = '{32'h00000001, 32'h134, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b1};
`else
    vecs[11] = '{32'h000290E7, 32'h12C, 7'h67, 5'd1, 3'd1, 5'd5, 5'd0, 7'h00, 32'h00000000, 1'b0};
    vecs[12] = '{32'hFFFFFFFF, 32'h130, 7'h7F, 5'd31, 3'd7, 5'd31, 5'd0, 7'h7F, 32'h00000000, 1'b0};
    vecs[13] = '{32'h00000001, 32'h134, 7'h01, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b0};
`endif

    bus.in_valid_i         = 1'b0;
    bus.instruction_word_i = '0;
    bus.pc_i               = '0;
    bus.flush_i            = 1'b0;
    bus.out_ready_i        = 1'b0;

    // Reset state.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("rst.valid",   64'(bus.out_valid_o), 64'd0);
    chk("rst.ready",   64'(bus.in_ready_o),  64'd1);
    chk("rst.illegal", 64'(bus.illegal_o),   64'd0);
    chk("rst.opcode",  64'(bus.opcode_o),    64'd0);
    chk("rst.imm",     64'(bus.imm_o),       64'd0);
    chk("rst.pc",      64'(bus.pc_o),        64'd0);
    $display("[TB] reset done");

    // Table: one word per cycle, downstream always ready.
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      bus.in_valid_i         = 1'b1;
      bus.instruction_word_i = vecs[i].instr;
      bus.pc_i               = vecs[i].pc;
      step();
      chk_bundle($sformatf("v%0d", i), vecs[i]);
      $display("[TB] vec %0d instr=%08h pc=%08h opcode=%02h imm=%08h illegal=%0b",
               i, vecs[i].instr, vecs[i].pc, bus.opcode_o, bus.imm_o, bus.illegal_o);
    end
    bus.in_valid_i = 1'b0;
    step();
    chk("drain.valid", 64'(bus.out_valid_o), 64'd0);
    $display("[TB] drain done");

    // Stall: word A accepted, B presented while downstream stalls.
    bus.in_valid_i = 1'b1; bus.instruction_word_i = 32'h00500093; bus.pc_i = 32'h200;
    step();
    chk("stall.a.pc", 64'(bus.pc_o), 64'h200);
    bus.instruction_word_i = 32'h002081B3; bus.pc_i = 32'h204; bus.out_ready_i = 1'b0;
    #1;
    chk("stall.in_ready", 64'(bus.in_ready_o), 64'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("stall.hold%0d.valid", k),  64'(bus.out_valid_o), 64'd1);
      chk($sformatf("stall.hold%0d.pc", k),     64'(bus.pc_o),        64'h200);
      chk($sformatf("stall.hold%0d.opcode", k), 64'(bus.opcode_o),    64'h13);
      chk($sformatf("stall.hold%0d.imm", k),    64'(bus.imm_o),       64'h5);
    end
    bus.out_ready_i = 1'b1;
    #1;
    chk("stall.release.in_ready", 64'(bus.in_ready_o), 64'd1);
    step();
    chk("stall.b.valid",  64'(bus.out_valid_o), 64'd1);
    chk("stall.b.pc",     64'(bus.pc_o),        64'h204);
    chk("stall.b.opcode", 64'(bus.opcode_o),    64'h33);
    bus.instruction_word_i = 32'h123450B7; bus.pc_i = 32'h208;
    step();
    chk("stall.c.valid",  64'(bus.out_valid_o), 64'd1);
    chk("stall.c.pc",     64'(bus.pc_o),        64'h208);
    chk("stall.c.opcode", 64'(bus.opcode_o),    64'h37);
    bus.in_valid_i = 1'b0;
    step();
    chk("stall.end.valid", 64'(bus.out_valid_o), 64'd0);
    $display("[TB] stall sequence done");

    // Flush with a held bundle and an incoming word.
    bus.in_valid_i = 1'b1; bus.instruction_word_i = 32'h00500093; bus.pc_i = 32'h300;
    bus.out_ready_i = 1'b0;
    step();
    chk("flush.held.valid", 64'(bus.out_valid_o), 64'd1);
    bus.instruction_word_i = 32'h002081B3; bus.pc_i = 32'h304;
    bus.flush_i = 1'b1; bus.out_ready_i = 1'b1;
    step();
    chk("flush.valid",  64'(bus.out_valid_o), 64'd0);
    chk("flush.pc",     64'(bus.pc_o),        64'h300);
    chk("flush.opcode", 64'(bus.opcode_o),    64'h13);
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    step();
    chk("flush.after.valid", 64'(bus.out_valid_o), 64'd0);
    $display("[TB] flush sequence done");

    // Reset while a bundle is stalled.
    bus.in_valid_i = 1'b1; bus.instruction_word_i = 32'hFE000EE3; bus.pc_i = 32'h400;
    bus.out_ready_i = 1'b0;
    step();
    chk("rststall.held.valid", 64'(bus.out_valid_o), 64'd1);
    bus.in_valid_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rststall.valid",    64'(bus.out_valid_o), 64'd0);
    chk("rststall.in_ready", 64'(bus.in_ready_o),  64'd1);
    chk("rststall.pc",       64'(bus.pc_o),        64'd0);
    chk("rststall.opcode",   64'(bus.opcode_o),    64'd0);
    chk("rststall.imm",      64'(bus.imm_o),       64'd0);
    $display("[TB] reset-in-stall sequence done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
